imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the 8-entry x 16-bit instruction store that the fetch/program-counter stage reads.
- Accepts a program as a stream of bytes over a valid/ready handshake, high byte first, and assembles each pair into one instruction word.
- Writes words sequentially from address 0 and signals completion.
- Provides a registered read port (address in, instruction and opcode out) for the fetch stage, replacing file-based instruction loading.

Parameters:
- DEPTH, 8, number of instruction words stored
- AW, 3, address width (log2 DEPTH)
- IW, 16, instruction width; opcode is bits [IW-1:IW-4]

Ports:
- clk  in  1  single clock, all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low; asserting low clears all state immediately
- start  in  1  one-cycle request to begin a load; accepted only in IDLE or DONE
- load_count  in  AW+1  number of words to load, 1..DEPTH; sampled when start is accepted
- byte_valid  in  1  byte stream valid
- byte_data  in  8  byte stream data
- byte_ready  out  1  loader can accept a byte this cycle
- rd_addr  in  AW  fetch read address (pc)
- rd_instr  out  IW  registered instruction at rd_addr
- rd_op  out  4  rd_instr[IW-1:IW-4]
- busy  out  1  high in LOAD_HI and LOAD_LO
- done  out  1  high in DONE
- err  out  1  sticky; set by a rejected start, cleared by an accepted valid start
- wr_count  out  AW+1  words written since the last accepted start

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; wr_ptr=0; wr_count=0; hi_reg=0.
  - All DEPTH memory words cleared to 0.
  - rd_instr=0, byte_ready=0, busy=0, done=0, err=0.
- Reset mid-load: the partial program is discarded (memory zeroed); a new start is required afterwards.
- Handshake: a byte transfers on a rising edge with byte_valid=1 and byte_ready=1. byte_ready depends only on state: it is 1 in LOAD_HI and LOAD_LO, 0 otherwise.
- IDLE and DONE states, on start=1:
  - load_count in 1..DEPTH: latch count; wr_ptr=0; wr_count=0; err=0; go to LOAD_HI. Memory is not cleared, so old words above the new count remain.
  - load_count=0 or load_count>DEPTH: err=1; state unchanged; nothing latched.
- LOAD_HI state: on transfer, hi_reg<=byte_data; go to LOAD_LO. No transfer means no change.
- LOAD_LO state, on transfer:
  - mem[wr_ptr]<={hi_reg, byte_data}; wr_ptr<=wr_ptr+1 (wraps mod DEPTH); wr_count<=wr_count+1.
  - If wr_count+1==count, go to DONE; otherwise go to LOAD_HI.
- start while busy is ignored; it does not set err.
- DONE: done=1 and byte_ready=0. Holds until start or reset.
- Read port:
  - Every rising edge, rd_instr<=mem[rd_addr]; 1-cycle latency, active in all states.
  - rd_op follows rd_instr combinationally.
  - Write and read to the same address in the same cycle return the OLD word; the new word is visible on the following read.
- Full load (count=DEPTH): the last write goes to address DEPTH-1. wr_ptr wraps to 0 but is unused because the state is DONE.
- Timing from the first high-byte transfer of a word:
  - The word is written at the edge of its low-byte transfer.
  - done rises on that same edge for the final word.
  - With continuous byte_valid, a count=N load takes 2N cycles from entering LOAD_HI.

Test Plan:
- Basic load:
  - Stimulus: reset; start with load_count=2; bytes 0x12,0x34,0xAB,0xCD sent back-to-back; then read addresses 0 and 1.
  - Required: done=1 exactly 4 cycles after LOAD_HI is entered; wr_count=2; rd_instr 0x1234 (rd_op=1), then 0xABCD (rd_op=0xA).
- Stalled source:
  - Stimulus: count=1; byte_valid toggles 1,0,0,1 with data 0x70, X, X, 0x05.
  - Required: mem[0]=0x7005; byte_ready stays 1 through the stall; no spurious write.
- Bad starts:
  - Stimulus: start with load_count=0, then start with load_count=9.
  - Required: err=1, state IDLE, byte_ready=0. A following start with load_count=3 clears err and sets busy=1.
- Full load:
  - Stimulus: count=8; words 0x0000..0x7777 (step 0x1111).
  - Required: done after 16 transfers; each address i reads 0x1111*i; start pulses during the load are ignored.
- Same-address read during write:
  - Stimulus: rd_addr=0 held during the write of 0xBEEF to address 0.
  - Required: rd_instr shows the old value (0x0000) on that edge and 0xBEEF one cycle later.
- Reset mid-load:
  - Stimulus: after 3 of 6 bytes, pull rst low asynchronously (between edges).
  - Required: outputs drop immediately (busy=0, byte_ready=0); every address reads 0x0000 afterwards; state IDLE.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-store writer: assembles a high-byte-first stream into 16-bit words,
// fills the DEPTH-entry store from address 0 and serves a registered fetch read port.
module imem_loader #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned IW    = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [AW:0]   i_load_count,
  input  logic          i_byte_valid,
  input  logic [7:0]    i_byte_data,
  output logic          o_byte_ready,
  input  logic [AW-1:0] i_rd_addr,
  output logic [IW-1:0] o_rd_instr,
  output logic [3:0]    o_rd_op,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [AW:0]   o_wr_count
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD_HI = 2'd1,
    S_LOAD_LO = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_wr_count;
  logic [CW-1:0]   r_count;
  logic [7:0]      r_hi;
  logic [IW-1:0]   r_mem [DEPTH];
  logic [IW-1:0]   r_rd_instr;
  logic            r_byte_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_err;

  logic            w_xfer;
  logic            w_count_ok;
  logic            w_last_word;

  assign w_xfer      = i_byte_valid && r_byte_ready;
  assign w_count_ok  = (i_load_count != CW'(0)) && (i_load_count <= CW'(DEPTH));
  assign w_last_word = (r_wr_count + CW'(1)) == r_count;

  // Controller, store and read port; flags are registered alongside the state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_wr_count   <= '0;
      r_count      <= '0;
      r_hi         <= '0;
      r_rd_instr   <= '0;
      r_byte_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // Reads sample the pre-write contents, so a same-address write shows next cycle.
      r_rd_instr <= r_mem[i_rd_addr];
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            if (w_count_ok) begin
              r_count      <= i_load_count;
              r_wr_ptr     <= '0;
              r_wr_count   <= '0;
              r_err        <= 1'b0;
              r_state      <= S_LOAD_HI;
              r_byte_ready <= 1'b1;
              r_busy       <= 1'b1;
              r_done       <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOAD_HI: begin
          if (w_xfer) begin
            r_hi    <= i_byte_data;
            r_state <= S_LOAD_LO;
          end
        end
        S_LOAD_LO: begin
          if (w_xfer) begin
            r_mem[r_wr_ptr] <= IW'({r_hi, i_byte_data});
            r_wr_ptr        <= r_wr_ptr + AW'(1);
            r_wr_count      <= r_wr_count + CW'(1);
            if (w_last_word) begin
              r_state      <= S_DONE;
              r_byte_ready <= 1'b0;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
            end else begin
              r_state <= S_LOAD_HI;
            end
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_byte_ready <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  assign o_byte_ready = r_byte_ready;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_wr_count   = r_wr_count;
  assign o_rd_instr   = r_rd_instr;
  assign o_rd_op      = r_rd_instr[IW-1 -: 4];

endmodule
